// File: rtl/io_sequencer_pkg.sv
// Shared I/O constants for the switch-read sequencer: FSM encodings,
// the default debounce length and a small zero-extension helper.
package io_sequencer_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;   // 10 ms at 50 MHz

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] seq_state_t;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE         = 2'd3;

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'b0, v};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchronizer plus a consecutive-sample
// debounce counter; emits one-cycle press/release pulses and the clean level.
module key_debouncer
    import io_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;
    logic             release_reg;

    // The count only runs while the synchronized sample differs from the
    // accepted level; any sample back at the old level clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg    <= 2'b11;
            level_reg   <= 1'b1;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], key_n};
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg     <= '0;
                level_reg   <= sync_reg[1];
                press_reg   <= ~sync_reg[1];
                release_reg <= sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign level         = level_reg;

endmodule

// File: rtl/io_sequencer.sv
// CPU I/O sequencer: display register write path plus a stall-driven
// switch read that waits for a debounced key press/release handshake.
module io_sequencer
    import io_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegToDisp,
    input  logic        SwToReg,
    input  logic [31:0] dado,
    input  logic [15:0] switches,
    input  logic        key_n,
    output logic        stall,
    output logic [31:0] dado_sw32,
    output logic [31:0] stdout,
    output logic        busy
);

    seq_state_t  state_reg, state_next;
    logic [31:0] stdout_reg;
    logic [31:0] dado_sw32_reg;
    logic [15:0] sw_meta_reg, sw_sync_reg;
    logic        capture;
    logic        press_pulse, release_pulse, key_level;
    logic        press_ok, release_ok;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sw_sync
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sw_meta_reg[gi] <= 1'b0;
                    sw_sync_reg[gi] <= 1'b0;
                end else begin
                    sw_meta_reg[gi] <= switches[gi];
                    sw_sync_reg[gi] <= sw_meta_reg[gi];
                end
            end
        end
    endgenerate

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .level        (key_level)
    );

    // Pulses are cross-checked against the settled level of key_n (active-low).
    assign press_ok   = press_pulse & ~key_level;
    assign release_ok = release_pulse & key_level;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (SwToReg) state_next = ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
                if (!SwToReg) begin
                    state_next = ST_IDLE;
                end else if (press_ok) begin
                    state_next = ST_WAIT_RELEASE;
                    capture    = 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (release_ok) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            stdout_reg    <= '0;
            dado_sw32_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (RegToDisp) stdout_reg <= dado;
            if (capture) dado_sw32_reg <= zext16(sw_sync_reg);
        end
    end

    // Reset gates stall so a held SwToReg cannot freeze the CPU during reset.
    assign stall     = reset & SwToReg & (state_reg != ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign stdout    = stdout_reg;
    assign dado_sw32 = dado_sw32_reg;

endmodule

// File: tb/tb_io_sequencer.sv
// Self-checking bench for io_sequencer with a short debounce length:
// display vector table, clean read, bounce rejection, abort, reset, overlap.
module tb_io_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegToDisp;
    logic        SwToReg;
    logic [31:0] dado;
    logic [15:0] switches;
    logic        key_n;
    logic        stall;
    logic [31:0] dado_sw32;
    logic [31:0] stdout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] disp_q[$];
    logic [31:0] cap_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp_stdout;
    } disp_vec_t;

    disp_vec_t vecs[6];

    io_sequencer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RegToDisp(RegToDisp),
        .SwToReg  (SwToReg),
        .dado     (dado),
        .switches (switches),
        .key_n    (key_n),
        .stall    (stall),
        .dado_sw32(dado_sw32),
        .stdout   (stdout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
        logic [31:0] e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = q.pop_front();
            check(name, act, e);
        end
    endtask

    initial begin
        logic        cap_seen;
        logic        done_seen;

        vecs[0] = '{1'b1, 32'h0000_00AA, 32'h0000_00AA};
        vecs[1] = '{1'b0, 32'h0000_1234, 32'h0000_00AA};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h1234_5678, 32'h1234_5678};

        // Reset with requests asserted: nothing may leak through.
        reset     = 1'b0;
        RegToDisp = 1'b1;
        SwToReg   = 1'b1;
        dado      = 32'hFFFF_FFFF;
        switches  = 16'hAAAA;
        key_n     = 1'b1;
        repeat (3) tick();
        check("rst_stdout", stdout, 32'h0);
        check("rst_dado_sw32", dado_sw32, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        RegToDisp = 1'b0;
        SwToReg   = 1'b0;
        #2 reset = 1'b1;
        tick();

        // Display path vector table
        for (int i = 0; i < 6; i++) begin
            RegToDisp = vecs[i].wr;
            dado      = vecs[i].data;
            disp_q.push_back(vecs[i].exp_stdout);
            tick();
            $display("disp vec %0d wr=%0b dado=%h stdout=%h", i, vecs[i].wr, vecs[i].data, stdout);
            check_pop("disp_stdout", stdout, disp_q);
            check("disp_stall", {31'b0, stall}, 32'h0);
        end
        RegToDisp = 1'b0;

        // Clean read of 0x1234
        switches = 16'h1234;
        SwToReg  = 1'b1;
        cap_q.push_back(32'h0000_1234);
        #1;
        check("req_cycle_stall", {31'b0, stall}, 32'h1);
        key_n     = 1'b0;
        cap_seen  = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 80 && !done_seen; c++) begin
            tick();
            if (c == 5) key_n = 1'b1;
            if (!cap_seen && dado_sw32 != 32'h0) begin
                cap_seen = 1'b1;
                $display("clean read captured %h at cycle %0d", dado_sw32, c);
                check_pop("clean_capture", dado_sw32, cap_q);
                check("clean_capture_busy", {31'b0, busy}, 32'h1);
                switches = 16'hFFFF;
            end
            if (!stall) done_seen = 1'b1;
        end
        check("clean_done_reached", {31'b0, done_seen}, 32'h1);
        check("clean_capture_before_done", {31'b0, cap_seen}, 32'h1);
        check("done_busy", {31'b0, busy}, 32'h1);
        tick();
        check("after_done_stall", {31'b0, stall}, 32'h1);
        check("after_done_idle", {31'b0, busy}, 32'h0);
        check("capture_held", dado_sw32, 32'h0000_1234);
        tick();
        check("rerequest_busy", {31'b0, busy}, 32'h1);

        // Abort in WAIT_PRESS
        SwToReg = 1'b0;
        tick();
        $display("abort: busy=%0b dado_sw32=%h", busy, dado_sw32);
        check("abort_idle", {31'b0, busy}, 32'h0);
        check("abort_dado_sw32", dado_sw32, 32'h0000_1234);

        // Bounce rejection
        switches = 16'hBEEF;
        SwToReg  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            key_n = ((c / 2) % 2) == 1;
            tick();
            check("bounce_no_capture", dado_sw32, 32'h0000_1234);
        end
        $display("bounce: busy=%0b stall=%0b dado_sw32=%h", busy, stall, dado_sw32);
        check("bounce_busy", {31'b0, busy}, 32'h1);
        check("bounce_stall", {31'b0, stall}, 32'h1);

        // Real press after bouncing; hold it to stay in WAIT_RELEASE
        cap_q.push_back(32'h0000_BEEF);
        key_n    = 1'b0;
        cap_seen = 1'b0;
        for (int c = 0; c < 30 && !cap_seen; c++) begin
            tick();
            if (dado_sw32 != 32'h0000_1234) cap_seen = 1'b1;
        end
        check("press2_seen", {31'b0, cap_seen}, 32'h1);
        check_pop("press2_capture", dado_sw32, cap_q);
        tick();
        check("wait_release_busy", {31'b0, busy}, 32'h1);
        check("wait_release_stall", {31'b0, stall}, 32'h1);

        // Asynchronous reset mid-operation
        #2 reset = 1'b0;
        #1;
        $display("midreset: busy=%0b stall=%0b dado_sw32=%h stdout=%h", busy, stall, dado_sw32, stdout);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_stall", {31'b0, stall}, 32'h0);
        check("midrst_dado_sw32", dado_sw32, 32'h0);
        check("midrst_stdout", stdout, 32'h0);
        key_n   = 1'b1;
        SwToReg = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();

        // Simultaneous display write and switch request
        SwToReg   = 1'b1;
        RegToDisp = 1'b1;
        dado      = 32'h0000_0055;
        disp_q.push_back(32'h0000_0055);
        tick();
        $display("simul: stdout=%h busy=%0b stall=%0b", stdout, busy, stall);
        check_pop("simul_stdout", stdout, disp_q);
        check("simul_busy", {31'b0, busy}, 32'h1);
        check("simul_stall", {31'b0, stall}, 32'h1);
        RegToDisp = 1'b0;
        SwToReg   = 1'b0;
        tick();
        check("simul_abort_idle", {31'b0, busy}, 32'h0);
        check("simul_dado_sw32", dado_sw32, 32'h0);
        check("simul_stdout_hold", stdout, 32'h0000_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/io_sequencer.md
IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable samples that qualify a key edge (10 ms at 50 MHz).
REQ-002 clk  input  1  single system clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 RegToDisp  input  1  CPU control: write dado to the display register this cycle.
REQ-005 SwToReg  input  1  CPU control: the instruction requests a switch read; held high by the CPU while stall is high.
REQ-006 dado  input  32  register value to display.
REQ-007 switches  input  16  DE2-115 switches SW[15:0], asynchronous to clk.
REQ-008 key_n  input  1  raw DE2-115 push button, active-low, asynchronous, bouncing.
REQ-009 stall  output  1  freezes the CPU PC and pipeline while high.
REQ-010 dado_sw32  output  32  captured switch value, zero-extended to 32 bits.
REQ-011 stdout  output  32  value driven to the 7-segment display decoder.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Display path shall be independent of the FSM: when RegToDisp=1 at a posedge, stdout shall take dado with 1-cycle latency; otherwise stdout holds its value.
REQ-014 switches and key_n shall each pass through a 2-flop synchronizer before use.
REQ-015 A key press is qualified after the synchronized key_n has been low for DEBOUNCE_CYCLES consecutive cycles; a release, after it has been high for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 Any change in the synchronized key level during counting restarts the debounce count from zero.
REQ-017 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-018 IDLE -> WAIT_PRESS when SwToReg=1; otherwise stay in IDLE.
REQ-019 WAIT_PRESS -> WAIT_RELEASE on a qualified press; on that same edge, dado_sw32 shall capture {16'b0, synchronized switches}.
REQ-020 WAIT_RELEASE -> DONE on a qualified release.
REQ-021 DONE -> IDLE unconditionally after one cycle.
REQ-022 stall = SwToReg AND (state != DONE). The output is combinational, so the request cycle itself stalls, and stall drops in exactly the single DONE cycle.
REQ-023 If SwToReg drops while in WAIT_PRESS, the FSM shall return to IDLE and dado_sw32 is unchanged.
REQ-024 A press already held when SwToReg rises shall be accepted only after its debounce count completes in WAIT_PRESS; no press is remembered from IDLE.
REQ-025 RegToDisp and SwToReg asserted together shall both be serviced, with no mutual priority.
REQ-026 dado_sw32 shall change only at the capture edge of REQ-019.

Reset
REQ-027 While reset=0, the block shall enter IDLE immediately, asynchronously, including mid-operation.
REQ-028 Reset values: stdout=0, dado_sw32=0, debounce counters=0, synchronizers=1 for key and 0 for switches.
REQ-029 During reset, stall=0 and busy=0.

Structure
REQ-030 State encodings and the default DEBOUNCE_CYCLES shall live in the shared I/O constants package/header.
REQ-031 The debounce counter and synchronizer shall be one sub-module, key_debouncer, parameterized by DEBOUNCE_CYCLES, with outputs press_pulse, release_pulse and level.
REQ-032 Counter width shall be $clog2(DEBOUNCE_CYCLES+1); no arithmetic wider than 32 bits.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Display write: RegToDisp=1 with dado=0x0000_00AA -> stdout=0xAA on the next edge; stall stays 0.
REQ-034 Clean read: switches=0x1234, SwToReg=1, key_n held low 6 cycles then high -> stall=1 from the request cycle; dado_sw32=0x0000_1234 after the press qualifies; stall=0 for exactly one cycle in DONE.
REQ-035 Bounce rejection: key_n toggles every 2 cycles for 20 cycles -> no capture, and the FSM stays in WAIT_PRESS with stall=1.
REQ-036 Mid-operation reset: reset pulsed low in WAIT_RELEASE -> immediate IDLE, dado_sw32=0, stdout=0, stall=0.
REQ-037 Simultaneous requests: RegToDisp=1 (dado=0x55) and SwToReg=1 in the same cycle -> stdout=0x55 next edge while the FSM enters WAIT_PRESS.
REQ-038 Request abort: SwToReg drops in WAIT_PRESS -> IDLE next edge, with dado_sw32 unchanged.
